// File: rtl/regaccess_burst_pkg.sv
// regaccess_burst_pkg: FSM state encoding and header-width derivation shared by the block
package regaccess_burst_pkg;
  typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;
  function automatic int hdr_w(input int addr_w);
    return addr_w + 2;
  endfunction
endpackage

// File: rtl/spi_shift_w.sv
// spi_shift_w: synchronised SPI mode-0 shift engine with runtime frame length and frame-done pulse
module spi_shift_w #(
  parameter int W  = 9,
  parameter int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          sck,
  input  logic          mosi,
  input  logic          en,
  input  logic          load,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  load_data,
  output logic          ss_s,
  output logic          done,
  output logic          miso,
  output logic [W-1:0]  frame
);
  logic ss_m, sck_m, sck_s, sck_q, mosi_m, mosi_s, rise, fall, last;
  logic [LW-1:0] cnt;
  logic [W-1:0] tx;
  assign rise = sck_s & ~sck_q;
  assign fall = ~sck_s & sck_q;
  assign last = cnt == len - 1'b1;
  // two-flop synchronisers; ss resets low so a select already low at reset release never looks like a fall
  always_ff @(posedge clk or negedge rst)
    if (!rst) {ss_m, ss_s, sck_m, sck_s, sck_q, mosi_m, mosi_s} <= '0;
    else {ss_m, ss_s, sck_m, sck_s, sck_q, mosi_m, mosi_s} <= {ss, ss_m, sck, sck_m, sck_s, mosi, mosi_m};
  // shift in on sck rise, shift out on sck fall; a load arriving with a fall still drives its MSB
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {done, miso, cnt, frame, tx} <= '0;
    end else if (!en) begin
      {done, miso, cnt, frame, tx} <= '0;
    end else begin
      done <= rise && last;
      if (rise) begin
        frame <= {frame[W-2:0], mosi_s};
        cnt   <= last ? '0 : cnt + 1'b1;
      end
      if (load) begin
        miso <= fall ? load_data[W-1] : miso;
        tx   <= fall ? load_data << 1 : load_data;
      end else if (fall) begin
        miso <= tx[W-1];
        tx   <= tx << 1;
      end
    end
endmodule

// File: rtl/regaccess_burst.sv
// regaccess_burst: SPI slave bridging burst header/data frames onto a register read/write strobe bus
module regaccess_burst
  import regaccess_burst_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  input  logic [DATA_W-1:0] rdata,
  output logic              wr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              err
);
  localparam int HDR_W = hdr_w(ADDR_W);
  localparam int W     = HDR_W > DATA_W ? HDR_W : DATA_W;
  localparam int LW    = $clog2(W + 1);
  localparam logic [ADDR_W:0]   NREG = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t st;
  logic ss_s, ss_q, done, rd_q, inc, bad;
  logic [W-1:0] frame, ld;
  logic [LW-1:0] len;
  logic [ADDR_W-1:0] nxt, h_addr;
  // frame length, next address and left-aligned read data for the shift engine
  always_comb begin
    len    = st == HDR ? LW'(HDR_W) : LW'(DATA_W);
    h_addr = frame[ADDR_W-1:0];
    bad    = {1'b0, h_addr} >= NREG;
    nxt    = !inc ? addr : (addr == LAST ? '0 : addr + 1'b1);
    ld     = W'(rdata) << (W - DATA_W);
  end
  spi_shift_w #(.W(W), .LW(LW)) u_shift (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
    .en(st != IDLE), .load(rd_q), .len(len), .load_data(ld),
    .ss_s(ss_s), .done(done), .miso(miso), .frame(frame)
  );
  // transaction FSM with registered strobes; rdata is loaded one cycle after each rd
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      {ss_q, rd, rd_q, wr, busy, err, inc} <= '0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      ss_q <= ss_s;
      rd   <= 1'b0;
      wr   <= 1'b0;
      rd_q <= rd;
      if (wr) addr <= nxt;
      if (ss_s) begin
        st   <= IDLE;
        busy <= 1'b0;
      end else case (st)
        IDLE: if (ss_q) begin
          st  <= HDR;
          err <= 1'b0;
        end
        HDR: if (done) begin
          st   <= frame[HDR_W-1] ? WDATA : RDATA;
          inc  <= frame[HDR_W-2];
          addr <= h_addr;
          busy <= 1'b1;
          err  <= bad;
          rd   <= !frame[HDR_W-1] && !bad;
        end
        WDATA: if (done) begin
          wr    <= !err;
          wdata <= frame[DATA_W-1:0];
        end
        RDATA: if (done) begin
          addr <= nxt;
          rd   <= !err;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_regaccess_burst.sv
// tb_regaccess_burst: directed SPI burst transactions against two instances (128 and 100 registers)
module tb_regaccess_burst;
  logic clk = 0, rst = 0, ss = 1, sck = 0, mosi = 0;
  logic miso_a, rd_a, wr_a, busy_a, err_a, miso_b, rd_b, wr_b, busy_b, err_b;
  logic [6:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b, rdata_a = 0;
  logic [7:0] rdata_b = 8'hFF;
  logic [15:0] rx_a, rx_b;
  logic [6:0] rd_log [64];
  logic [6:0] wr_alog [64];
  logic [7:0] wr_dlog [64];
  int rd_cnt = 0, wr_cnt = 0, rd_b_cnt = 0, wr_b_cnt = 0, viol = 0, n_cmp = 0, n_bad = 0;
  logic rd_p = 0, wr_p = 0;
  always #5 clk = ~clk;
  regaccess_burst dut_a (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso_a), .addr(addr_a),
    .rd(rd_a), .rdata(rdata_a), .wr(wr_a), .wdata(wdata_a), .busy(busy_a), .err(err_a)
  );
  regaccess_burst #(.NUM_REGS(100)) dut_b (
    .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso_b), .addr(addr_b),
    .rd(rd_b), .rdata(rdata_b), .wr(wr_b), .wdata(wdata_b), .busy(busy_b), .err(err_b)
  );
  always @(posedge clk) if (rd_a) rdata_a <= 8'(addr_a) + 8'd1;
  always @(negedge clk) begin
    if (rd_a) begin rd_log[rd_cnt % 64] = addr_a; rd_cnt++; end
    if (wr_a) begin wr_alog[wr_cnt % 64] = addr_a; wr_dlog[wr_cnt % 64] = wdata_a; wr_cnt++; end
    if (rd_b) rd_b_cnt++;
    if (wr_b) wr_b_cnt++;
    if ((rd_a && wr_a) || (rd_a && rd_p) || (wr_a && wr_p)) viol++;
    rd_p = rd_a;
    wr_p = wr_a;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int n, input logic [15:0] d);
    rx_a = 0;
    rx_b = 0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      #60 sck = 1;
      rx_a = {rx_a[14:0], miso_a};
      rx_b = {rx_b[14:0], miso_b};
      #60 sck = 0;
    end
  endtask
  task automatic sel;
    ss = 0;
    #60;
  endtask
  task automatic desel;
    #60 ss = 1;
    #200;
  endtask
  int r0, w0, rb0, wb0, bad;
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("rst_addr", addr_a, 0);
    chk("rst_strobes", {rd_a, wr_a}, 0);
    chk("rst_flags", {busy_a, err_a, miso_a}, 0);
    chk("rst_wdata", wdata_a, 0);
    @(negedge clk) rst = 1;
    #100;
    // burst write with increment
    w0 = wr_cnt; r0 = rd_cnt;
    sel; xfer(9, 16'h190);
    chk("wr_busy", busy_a, 1);
    xfer(8, 16'hA5); xfer(8, 16'h5A); desel;
    chk("wr_cnt", wr_cnt - w0, 2);
    chk("wr0", {wr_alog[w0 % 64], wr_dlog[w0 % 64]}, {7'h10, 8'hA5});
    chk("wr1", {wr_alog[(w0 + 1) % 64], wr_dlog[(w0 + 1) % 64]}, {7'h11, 8'h5A});
    chk("wr_err", err_a, 0);
    chk("wr_no_rd", rd_cnt - r0, 0);
    chk("idle_busy", busy_a, 0);
    // burst read with wrap at the top of the map
    r0 = rd_cnt;
    sel; xfer(9, 16'h0FF);
    xfer(8, 0); chk("wrap_b0", rx_a[7:0], 8'h80);
    xfer(8, 0); chk("wrap_b1", rx_a[7:0], 8'h01);
    xfer(8, 0); chk("wrap_b2", rx_a[7:0], 8'h02);
    desel;
    chk("wrap_addr", {rd_log[r0 % 64], rd_log[(r0 + 1) % 64], rd_log[(r0 + 2) % 64]}, {7'h7F, 7'h00, 7'h01});
    // read with fixed address
    r0 = rd_cnt;
    sel; xfer(9, 16'h005);
    for (int f = 0; f < 4; f++) begin
      xfer(8, 0);
      chk("fix_data", rx_a[7:0], 8'h06);
    end
    desel;
    chk("fix_rd_min4", rd_cnt - r0 >= 4, 1);
    bad = 0;
    for (int i = r0; i < rd_cnt; i++) if (rd_log[i % 64] != 7'h05) bad++;
    chk("fix_addr", bad, 0);
    // out-of-range header on the 100-register instance
    rb0 = rd_b_cnt; wb0 = wr_b_cnt;
    sel; xfer(9, 16'h0E4);
    xfer(8, 0); chk("oor_miso0", rx_b[7:0], 0); chk("inr_miso0", rx_a[7:0], 8'h65);
    xfer(8, 0); chk("oor_miso1", rx_b[7:0], 0);
    desel;
    chk("oor_err", err_b, 1);
    chk("inr_err", err_a, 0);
    chk("oor_strobes", (rd_b_cnt - rb0) + (wr_b_cnt - wb0), 0);
    // err clears on the next select; then a write aborted mid-frame
    w0 = wr_cnt;
    ss = 0;
    repeat (5) @(posedge clk);
    #1 chk("err_clear", err_b, 0);
    #60 xfer(9, 16'h1A0); xfer(8, 16'h33);
    for (int i = 7; i >= 3; i--) begin
      mosi = i[0];
      #60 sck = 1;
      #60 sck = 0;
    end
    @(negedge clk);
    chk("abort_busy_hi", busy_a, 1);
    ss = 1;
    repeat (3) @(posedge clk);
    #1 chk("abort_busy_lo", busy_a, 0);
    #200;
    chk("abort_wr_cnt", wr_cnt - w0, 1);
    chk("abort_wr0", {wr_alog[w0 % 64], wr_dlog[w0 % 64]}, {7'h20, 8'h33});
    w0 = wr_cnt;
    sel; xfer(9, 16'h130); xfer(8, 16'h77); xfer(8, 16'h78); desel;
    chk("after_cnt", wr_cnt - w0, 2);
    chk("after_wr", {wr_alog[w0 % 64], wr_dlog[w0 % 64], wr_alog[(w0 + 1) % 64], wr_dlog[(w0 + 1) % 64]},
        {7'h30, 8'h77, 7'h30, 8'h78});
    // reset mid-read with select held low
    sel; xfer(9, 16'h0C0);
    xfer(8, 0); chk("pre_rst_data", rx_a[7:0], 8'h41);
    for (int i = 0; i < 3; i++) begin #60 sck = 1; #60 sck = 0; end
    rst = 0;
    #5 chk("mid_rst_outs", {addr_a, rd_a, wr_a, wdata_a, busy_a, err_a, miso_a}, 0);
    @(negedge clk) rst = 1;
    r0 = rd_cnt; w0 = wr_cnt;
    xfer(9, 16'h0C0); xfer(8, 0);
    chk("post_rst_miso", rx_a[7:0], 0);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    desel;
    sel; xfer(9, 16'h087); xfer(8, 0); desel;
    chk("resume_data", rx_a[7:0], 8'h08);
    chk("resume_addr", rd_log[r0 % 64], 7'h07);
    chk("strobe_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
